// File: rtl/stim_seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : stim_seq_checker_if
// Description : Run-control, stimulus and result bundle of stim_seq_checker.
// Revision    : 1.0
// ============================================================================
interface stim_seq_checker_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 8
);
    logic             start;
    logic             dut_out;
    logic [N_IN-1:0]  stim;
    logic             stim_valid;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err_count;
    logic             first_err_valid;
    logic [N_IN-1:0]  first_err_vec;

    // Master is the bench side that wires the DUT; slave is the checker.
    modport master (
        output start,
        output dut_out,
        input  stim,
        input  stim_valid,
        input  busy,
        input  done,
        input  err_count,
        input  first_err_valid,
        input  first_err_vec
    );

    modport slave (
        input  start,
        input  dut_out,
        output stim,
        output stim_valid,
        output busy,
        output done,
        output err_count,
        output first_err_valid,
        output first_err_vec
    );
endinterface
`default_nettype wire

// File: rtl/stim_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : stim_seq_checker
// Description : Walks all 2**N_IN input vectors (binary or Gray order) into a
//               combinational DUT and scores its output against EXPECTED.
// Revision    : 1.0
// ============================================================================
module stim_seq_checker #(
    parameter int                      N_IN     = 2,
    parameter int                      HOLD     = 3,
    parameter logic [(2**N_IN)-1:0]    EXPECTED = 4'b0110,
    parameter int                      GRAY     = 0,
    parameter int                      ERR_W    = 8
) (
    input  wire logic          clock,
    input  wire logic          reset,
    stim_seq_checker_if.slave  bus
);
    localparam int               HC_W        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0]  C_HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [N_IN-1:0]  C_IDX_LAST  = '1;
    localparam logic [ERR_W-1:0] C_ERR_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_IN-1:0]  r_idx;
    logic [HC_W-1:0]  r_hold_cnt;
    logic [ERR_W-1:0] r_err_count;
    logic             r_first_err_valid;
    logic [N_IN-1:0]  r_first_err_vec;

    logic [N_IN-1:0]  w_stim;
    logic             w_start_ok;
    logic             w_sample;
    logic             w_mismatch;

    // stim is a pure function of idx, so it reads 0 after reset and keeps the
    // last vector in DONE without a separate register.
    generate
        if (GRAY != 0) begin : g_gray
            assign w_stim = r_idx ^ (r_idx >> 1);
        end else begin : g_binary
            assign w_stim = r_idx;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_sample    = 1'b0;
        w_mismatch  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_start_ok  = 1'b1;
                end
            end
            S_RUN: begin
                w_sample   = (r_hold_cnt == C_HOLD_LAST);
                w_mismatch = w_sample && (bus.dut_out != EXPECTED[w_stim]);
                if (w_sample && (r_idx == C_IDX_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx             <= '0;
            r_hold_cnt        <= '0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= '0;
        end else if (w_start_ok) begin
            r_idx             <= '0;
            r_hold_cnt        <= '0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= '0;
        end else if (r_state == S_RUN) begin
            if (w_sample) begin
                if (w_mismatch) begin
                    if (r_err_count != C_ERR_MAX) begin
                        r_err_count <= r_err_count + 1'b1;
                    end
                    if (!r_first_err_valid) begin
                        r_first_err_valid <= 1'b1;
                        r_first_err_vec   <= w_stim;
                    end
                end
                // The last index leaves idx untouched so stim holds in DONE.
                if (r_idx != C_IDX_LAST) begin
                    r_idx      <= r_idx + 1'b1;
                    r_hold_cnt <= '0;
                end
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign bus.stim            = w_stim;
    assign bus.stim_valid      = (r_state == S_RUN);
    assign bus.busy            = (r_state == S_RUN);
    assign bus.done            = (r_state == S_DONE);
    assign bus.err_count       = r_err_count;
    assign bus.first_err_valid = r_first_err_valid;
    assign bus.first_err_vec   = r_first_err_vec;

endmodule
`default_nettype wire

// File: tb/tb_stim_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_stim_seq_checker
// Description : Scoreboard bench for stim_seq_checker across three configs.
// Revision    : 1.0
// ============================================================================
module tb_stim_seq_checker;
    localparam logic [3:0] EXP_A = 4'b0110;
    localparam logic [3:0] EXP_B = 4'b0110;
    localparam logic [7:0] EXP_C = 8'h96;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mode_a = 1'b0;   // 0: XOR DUT, 1: OR DUT

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic [2:0] qc[$];

    stim_seq_checker_if #(.N_IN(2), .ERR_W(8)) ifa ();
    stim_seq_checker_if #(.N_IN(2), .ERR_W(8)) ifb ();
    stim_seq_checker_if #(.N_IN(3), .ERR_W(2)) ifc ();

    stim_seq_checker #(.N_IN(2), .HOLD(3), .EXPECTED(EXP_A), .GRAY(0), .ERR_W(8)) u_a (
        .clock (clock), .reset (reset), .bus (ifa.slave));
    stim_seq_checker #(.N_IN(2), .HOLD(1), .EXPECTED(EXP_B), .GRAY(1), .ERR_W(8)) u_b (
        .clock (clock), .reset (reset), .bus (ifb.slave));
    stim_seq_checker #(.N_IN(3), .HOLD(3), .EXPECTED(EXP_C), .GRAY(0), .ERR_W(2)) u_c (
        .clock (clock), .reset (reset), .bus (ifc.slave));

    always #5 clock = ~clock;

    assign ifa.dut_out = mode_a ? (|ifa.stim) : (^ifa.stim);
    assign ifb.dut_out = ^ifb.stim;
    assign ifc.dut_out = ~EXP_C[ifc.stim];

    // Scoreboard monitors: every valid stim cycle consumes one expected vector.
    always @(negedge clock) begin
        if (ifa.stim_valid) begin
            n_checks++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL stim_a_extra: got stim=%0d, required no valid vector", ifa.stim);
            end else begin
                logic [1:0] e;
                e = qa.pop_front();
                if (ifa.stim !== e) begin
                    n_fail++;
                    $display("FAIL stim_a_seq: got %0d, required %0d", ifa.stim, e);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (ifb.stim_valid) begin
            n_checks++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL stim_b_extra: got stim=%0d, required no valid vector", ifb.stim);
            end else begin
                logic [1:0] e;
                e = qb.pop_front();
                if (ifb.stim !== e) begin
                    n_fail++;
                    $display("FAIL stim_b_seq: got %0d, required %0d", ifb.stim, e);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (ifc.stim_valid) begin
            n_checks++;
            if (qc.size() == 0) begin
                n_fail++;
                $display("FAIL stim_c_extra: got stim=%0d, required no valid vector", ifc.stim);
            end else begin
                logic [2:0] e;
                e = qc.pop_front();
                if (ifc.stim !== e) begin
                    n_fail++;
                    $display("FAIL stim_c_seq: got %0d, required %0d", ifc.stim, e);
                end
            end
        end
    end

    task automatic push_seq(input int sel);
        case (sel)
            0: for (int v = 0; v < 4; v++) repeat (3) qa.push_back(2'(v));
            1: for (int v = 0; v < 4; v++) qb.push_back(2'(v ^ (v >> 1)));
            default: for (int v = 0; v < 8; v++) repeat (3) qc.push_back(3'(v));
        endcase
    endtask

    task automatic start_pulse(input int sel);
        @(posedge clock); #1;
        case (sel)
            0: ifa.start = 1'b1;
            1: ifb.start = 1'b1;
            default: ifc.start = 1'b1;
        endcase
        @(posedge clock); #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
    endtask

    // Counts valid cycles and total cycles until done; optional start pulse on A.
    task automatic wait_done(input int sel, input int inj_at, output int nvalid, output int ncyc);
        logic v, d;
        nvalid = 0;
        ncyc   = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            ncyc++;
            ifa.start = (sel == 0) && (ncyc == inj_at);
            case (sel)
                0: begin v = ifa.stim_valid; d = ifa.done; end
                1: begin v = ifb.stim_valid; d = ifb.done; end
                default: begin v = ifc.stim_valid; d = ifc.done; end
            endcase
            if (v) nvalid++;
            if (d) break;
        end
        ifa.start = 1'b0;
    endtask

    task automatic test_reset();
        ifa.start = 1'b1;
        ifb.start = 1'b1;
        ifc.start = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({ifa.stim, ifa.stim_valid, ifa.busy, ifa.done, ifa.err_count,
             ifa.first_err_valid, ifa.first_err_vec} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_a: outputs=%h, required 0", {ifa.stim, ifa.stim_valid, ifa.busy,
                     ifa.done, ifa.err_count, ifa.first_err_valid, ifa.first_err_vec});
        end
        n_checks++;
        if ({ifb.busy, ifb.done, ifc.busy, ifc.done, ifc.err_count, ifc.stim} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_bc: outputs=%h, required 0",
                     {ifb.busy, ifb.done, ifc.busy, ifc.done, ifc.err_count, ifc.stim});
        end
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_xor_run();
        int nv, nc;
        mode_a = 1'b0;
        push_seq(0);
        start_pulse(0);
        wait_done(0, 0, nv, nc);
        n_checks++;
        if (nv !== 12 || nc !== 13) begin
            n_fail++;
            $display("FAIL xor_timing: valid=%0d cycles=%0d, required 12 and 13", nv, nc);
        end
        n_checks++;
        if (qa.size() !== 0) begin
            n_fail++;
            $display("FAIL xor_queue: %0d vectors left, required 0", qa.size());
        end
        n_checks++;
        if (ifa.err_count !== 8'd0 || ifa.first_err_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL xor_result: err=%0d fev=%0b, required 0 0", ifa.err_count, ifa.first_err_valid);
        end
        n_checks++;
        if (ifa.stim !== 2'd3 || ifa.stim_valid !== 1'b0 || ifa.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL xor_done_state: stim=%0d valid=%0b busy=%0b, required 3 0 0",
                     ifa.stim, ifa.stim_valid, ifa.busy);
        end
    endtask

    task automatic test_or_run();
        int nv, nc, exp_err;
        logic [1:0] exp_vec;
        logic found;
        exp_err = 0;
        exp_vec = 2'd0;
        found   = 1'b0;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] s;
            s = 2'(v);
            if ((|s) != EXP_A[v]) begin
                exp_err++;
                if (!found) begin exp_vec = s; found = 1'b1; end
            end
        end
        mode_a = 1'b1;
        push_seq(0);
        start_pulse(0);
        wait_done(0, 0, nv, nc);
        n_checks++;
        if (ifa.err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL or_err_count: got %0d, required %0d", ifa.err_count, exp_err);
        end
        n_checks++;
        if (ifa.first_err_valid !== found || ifa.first_err_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL or_first_err: fev=%0b vec=%0d, required %0b %0d",
                     ifa.first_err_valid, ifa.first_err_vec, found, exp_vec);
        end
    endtask

    task automatic test_restart_from_done();
        int nv, nc;
        mode_a = 1'b0;
        push_seq(0);
        start_pulse(0);
        n_checks++;
        if (ifa.err_count !== 8'd0 || ifa.first_err_valid !== 1'b0 || ifa.done !== 1'b0 ||
            ifa.busy !== 1'b1 || ifa.stim !== 2'd0) begin
            n_fail++;
            $display("FAIL restart_clear: err=%0d fev=%0b done=%0b busy=%0b stim=%0d, required 0 0 0 1 0",
                     ifa.err_count, ifa.first_err_valid, ifa.done, ifa.busy, ifa.stim);
        end
        wait_done(0, 5, nv, nc);
        n_checks++;
        if (nv !== 12 || nc !== 13) begin
            n_fail++;
            $display("FAIL start_in_run_timing: valid=%0d cycles=%0d, required 12 and 13", nv, nc);
        end
        n_checks++;
        if (ifa.err_count !== 8'd0 || qa.size() !== 0) begin
            n_fail++;
            $display("FAIL start_in_run_result: err=%0d left=%0d, required 0 0", ifa.err_count, qa.size());
        end
    endtask

    task automatic test_gray();
        int nv, nc;
        push_seq(1);
        start_pulse(1);
        wait_done(1, 0, nv, nc);
        n_checks++;
        if (nv !== 4 || nc !== 5) begin
            n_fail++;
            $display("FAIL gray_timing: valid=%0d cycles=%0d, required 4 and 5", nv, nc);
        end
        n_checks++;
        if (qb.size() !== 0 || ifb.err_count !== 8'd0 || ifb.stim !== 2'd2) begin
            n_fail++;
            $display("FAIL gray_result: left=%0d err=%0d stim=%0d, required 0 0 2",
                     qb.size(), ifb.err_count, ifb.stim);
        end
    endtask

    task automatic test_saturate();
        int nv, nc;
        push_seq(2);
        start_pulse(2);
        wait_done(2, 0, nv, nc);
        n_checks++;
        if (nv !== 24 || qc.size() !== 0) begin
            n_fail++;
            $display("FAIL sat_timing: valid=%0d left=%0d, required 24 0", nv, qc.size());
        end
        n_checks++;
        if (ifc.err_count !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_err_count: got %0d, required 3", ifc.err_count);
        end
        n_checks++;
        if (ifc.first_err_valid !== 1'b1 || ifc.first_err_vec !== 3'd0) begin
            n_fail++;
            $display("FAIL sat_first_err: fev=%0b vec=%0d, required 1 0", ifc.first_err_valid, ifc.first_err_vec);
        end
    endtask

    task automatic test_reset_midrun();
        int nv, nc;
        logic hit;
        mode_a = 1'b0;
        push_seq(0);
        start_pulse(0);
        hit = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (ifa.stim_valid && ifa.stim == 2'd2) begin hit = 1'b1; break; end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL midrun_reach_idx2: got timeout, required stim=2 in RUN");
        end
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({ifa.stim, ifa.stim_valid, ifa.busy, ifa.done, ifa.err_count,
             ifa.first_err_valid, ifa.first_err_vec} !== 15'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: outputs=%h, required 0", {ifa.stim, ifa.stim_valid, ifa.busy,
                     ifa.done, ifa.err_count, ifa.first_err_valid, ifa.first_err_vec});
        end
        reset = 1'b0;
        qa.delete();
        push_seq(0);
        start_pulse(0);
        wait_done(0, 0, nv, nc);
        n_checks++;
        if (nv !== 12 || ifa.err_count !== 8'd0 || qa.size() !== 0) begin
            n_fail++;
            $display("FAIL midrun_rerun: valid=%0d err=%0d left=%0d, required 12 0 0",
                     nv, ifa.err_count, qa.size());
        end
    endtask

    initial begin
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        test_reset();
        test_xor_run();
        test_or_run();
        test_restart_from_done();
        test_gray();
        test_saturate();
        test_reset_midrun();
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
